spi_reg_responder: RTL and testbench

- SPI responder (slave end) that decodes a command byte from the SPI master and serves reads and writes into a local 8-bit register file.
- Shares the system clock with the master; framing uses an active-low chip select; one bit moves per clock.
- Sits beside the slave instances as a register-mapped endpoint, so the master can configure and read back peripherals.

---
 rtl/spi_reg_responder.sv | 127 ++++++++++++
 tb/tb_spi_reg_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/spi_reg_responder.sv
// spi_reg_responder: SPI responder serving burst reads/writes of a local 8-bit register file.
// Define SPI_FRAME_ERR_EN to add a sticky frame_err flag for frames aborted mid-byte.
module spi_reg_responder #(
   parameter int ADDR_W = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cs_n,
   input  logic                       mode,
   input  logic                       mosi,
   output logic                       miso,
   output logic                       byte_done,
`ifdef SPI_FRAME_ERR_EN
   output logic                       frame_err,
`endif
   input  logic                       loc_we,
   input  logic [ADDR_W-1:0]          loc_addr,
   input  logic [7:0]                 loc_wdata,
   output logic [8*(2**ADDR_W)-1:0]   regs_flat
);
   localparam int N = 2**ADDR_W;
   typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;
   state_t            state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d, addr_nx;
   logic [7:0]        rx_q, rx_d, rx_in, tx_q, tx_d, ld_byte, ld_tx;
   logic              miso_q, miso_d, byte_done_q, byte_done_d, last, ld_bit;
   logic [7:0]        regs_q [N];
   logic [7:0]        regs_d [N];
`ifdef SPI_FRAME_ERR_EN
   logic              frame_err_q, frame_err_d;
   assign frame_err = frame_err_q;
`endif
   assign miso      = miso_q;
   assign byte_done = byte_done_q;
   for (genvar i = 0; i < N; i++) begin : g_flat
      assign regs_flat[8*i +: 8] = regs_q[i];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         addr_q      <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         miso_q      <= 1'b0;
         byte_done_q <= 1'b0;
         regs_q      <= '{default: '0};
`ifdef SPI_FRAME_ERR_EN
         frame_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         addr_q      <= addr_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         miso_q      <= miso_d;
         byte_done_q <= byte_done_d;
         regs_q      <= regs_d;
`ifdef SPI_FRAME_ERR_EN
         frame_err_q <= frame_err_d;
`endif
      end
   end
   // The load source is the decoded start address in CMD, else the next burst address.
   always_comb begin
      rx_in       = mode ? {mosi, rx_q[7:1]} : {rx_q[6:0], mosi};
      last        = bit_cnt_q == 3'd7;
      addr_nx     = addr_q + 1'b1;
      ld_byte     = (state_q == CMD) ? regs_q[rx_in[ADDR_W-1:0]] : regs_q[addr_nx];
      ld_bit      = mode ? ld_byte[0] : ld_byte[7];
      ld_tx       = mode ? ld_byte >> 1 : ld_byte << 1;
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q + 3'd1;
      addr_d      = addr_q;
      rx_d        = rx_in;
      tx_d        = tx_q;
      miso_d      = 1'b0;
      byte_done_d = 1'b0;
      regs_d      = regs_q;
`ifdef SPI_FRAME_ERR_EN
      frame_err_d = frame_err_q;
`endif
      if (loc_we) regs_d[loc_addr] = loc_wdata;
      if (cs_n) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         rx_d      = rx_q;
`ifdef SPI_FRAME_ERR_EN
         if (state_q != IDLE && bit_cnt_q != 3'd0) frame_err_d = 1'b1;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               state_d   = CMD;
               bit_cnt_d = 3'd1;
            end
            CMD: if (last) begin
               state_d = rx_in[7] ? WDATA : RDATA;
               addr_d  = rx_in[ADDR_W-1:0];
               if (!rx_in[7]) begin
                  tx_d   = ld_tx;
                  miso_d = ld_bit;
               end
            end
            WDATA: if (last) begin
               regs_d[addr_q] = rx_in;
               addr_d         = addr_nx;
               byte_done_d    = 1'b1;
`ifdef SPI_FRAME_ERR_EN
               if (rx_in == 8'hFF && addr_q == {ADDR_W{1'b1}}) frame_err_d = 1'b0;
`endif
            end
            RDATA: begin
               miso_d = last ? ld_bit : (mode ? tx_q[0] : tx_q[7]);
               tx_d   = last ? ld_tx : (mode ? tx_q >> 1 : tx_q << 1);
               if (last) begin
                  addr_d      = addr_nx;
                  byte_done_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_reg_responder.sv
// tb_spi_reg_responder: directed bench for spi_reg_responder (ADDR_W=2).
// Inputs change and outputs are sampled on the falling edge.
module tb_spi_reg_responder;
   localparam int ADDR_W = 2;
   logic              clk = 1'b0, rst = 1'b1, cs_n = 1'b1, mode = 1'b0, mosi = 1'b0, loc_we = 1'b0;
   logic [ADDR_W-1:0] loc_addr = '0;
   logic [7:0]        loc_wdata = '0;
   logic              miso, byte_done;
   logic [31:0]       regs_flat;
`ifdef SPI_FRAME_ERR_EN
   logic              frame_err;
`endif
   int                total = 0, bad = 0, bd_cnt = 0;
   logic [15:0]       obs;
   always #5 clk = ~clk;
   spi_reg_responder #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .cs_n(cs_n), .mode(mode), .mosi(mosi), .miso(miso),
      .byte_done(byte_done),
`ifdef SPI_FRAME_ERR_EN
      .frame_err(frame_err),
`endif
      .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .regs_flat(regs_flat)
   );
   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask
   task automatic send_bit(input logic b);
      cs_n = 1'b0;
      mosi = b;
      @(negedge clk);
      bd_cnt += int'(byte_done);
   endtask
   task automatic idle();
      cs_n = 1'b1;
      mosi = 1'b0;
      @(negedge clk);
      bd_cnt += int'(byte_done);
   endtask
   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) send_bit(mode ? v[i] : v[7-i]);
   endtask
   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_regs", regs_flat, 32'h0);
      chk("rst_miso", miso, 1'b0);
      chk("rst_bd", byte_done, 1'b0);
`ifdef SPI_FRAME_ERR_EN
      chk("rst_ferr", frame_err, 1'b0);
`endif
      rst = 1'b0;
      idle();
      // write 0xA5 to reg1, MSB first
      bd_cnt = 0;
      send_bits(8'h81, 8);
      send_bits(8'hA5, 7);
      chk("wr_pre_bd", byte_done, 1'b0);
      chk("wr_pre_reg", regs_flat[15:8], 8'h00);
      send_bit(1'b1);
      chk("wr_reg1", regs_flat[15:8], 8'hA5);
      chk("wr_bd", byte_done, 1'b1);
      idle();
      chk("wr_bd_off", byte_done, 1'b0);
      chk("wr_bd_cnt", bd_cnt, 1);
      // reset during the 5th command bit
      send_bits(8'h81, 4);
      mosi = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_regs", regs_flat, 32'h0);
      chk("mid_rst_miso", miso, 1'b0);
      rst = 1'b0;
      idle();
      // LSB-first read of reg2 with a local write landing mid-byte
      loc_we = 1'b1; loc_addr = 2'd2; loc_wdata = 8'h3C;
      @(negedge clk);
      loc_we = 1'b0;
      chk("loc_reg2", regs_flat[23:16], 8'h3C);
      mode = 1'b1;
      bd_cnt = 0;
      send_bits(8'h02, 8);
      obs = '0;
      for (int i = 0; i < 8; i++) begin
         obs[i] = miso;
         loc_we = (i == 2);
         loc_wdata = 8'hFF;
         send_bit(1'b0);
      end
      loc_we = 1'b0;
      chk("rd_lsb_data", obs[7:0], 8'h3C);
      chk("rd_bd", byte_done, 1'b1);
      chk("rd_snap_reg2", regs_flat[23:16], 8'hFF);
      idle();
      chk("rd_miso_idle", miso, 1'b0);
      chk("rd_bd_cnt", bd_cnt, 1);
      mode = 1'b0;
      idle();
      // burst write wrapping from reg3 to reg0
      bd_cnt = 0;
      send_bits(8'h83, 8);
      send_bits(8'h11, 8);
      chk("burst_bd1", byte_done, 1'b1);
      send_bits(8'h22, 8);
      chk("burst_bd2", byte_done, 1'b1);
      send_bits(8'h33, 8);
      chk("burst_bd3", byte_done, 1'b1);
      idle();
      chk("burst_regs", regs_flat, 32'h11FF3322);
      chk("burst_bd_cnt", bd_cnt, 3);
      // abort after 4 data bits, then restart on the very next cycle
      bd_cnt = 0;
      send_bits(8'h80, 8);
      send_bits(8'hF0, 4);
      idle();
      chk("abort_reg0", regs_flat[7:0], 8'h22);
      chk("abort_bd_cnt", bd_cnt, 0);
`ifdef SPI_FRAME_ERR_EN
      chk("abort_ferr", frame_err, 1'b1);
`endif
      send_bits(8'h81, 8);
      send_bits(8'h5A, 7);
      loc_we = 1'b1; loc_addr = 2'd1; loc_wdata = 8'h77;
      send_bit(1'b0);
      loc_we = 1'b0;
      idle();
      chk("conflict_reg1", regs_flat[15:8], 8'h5A);
      send_bits(8'h82, 8);
      send_bits(8'h44, 7);
      loc_we = 1'b1; loc_addr = 2'd0; loc_wdata = 8'h99;
      send_bit(1'b0);
      loc_we = 1'b0;
      idle();
      chk("both_reg2", regs_flat[23:16], 8'h44);
      chk("both_reg0", regs_flat[7:0], 8'h99);
      send_bits(8'h83, 8);
      send_bits(8'hFF, 8);
      idle();
      chk("ff_reg3", regs_flat[31:24], 8'hFF);
`ifdef SPI_FRAME_ERR_EN
      chk("ff_ferr_clr", frame_err, 1'b0);
`endif
      // MSB-first two-byte read burst, reg1 then reg2 with no gap bit
      bd_cnt = 0;
      send_bits(8'h01, 8);
      obs = '0;
      for (int i = 0; i < 16; i++) begin
         obs = {obs[14:0], miso};
         send_bit(1'b0);
      end
      idle();
      chk("rd_msb_burst", obs, 16'h5A44);
      chk("rd_msb_bd_cnt", bd_cnt, 2);
      chk("final_regs", regs_flat, 32'hFF445A99);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
